// File: rtl/uart_tx_framer_pkg.sv
// Shared UART encodings and FSM state type, reused by the Tx framer and the Rx side.
package uart_tx_framer_pkg;

   typedef enum logic [1:0] {
      PAR_NONE0 = 2'b00,
      PAR_ODD   = 2'b01,
      PAR_EVEN  = 2'b10,
      PAR_NONE3 = 2'b11
   } parity_e;

   typedef enum logic {
      LEN_7 = 1'b0,
      LEN_8 = 1'b1
   } len_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   function automatic logic parity_enabled(input parity_e ptype);
      return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
   endfunction

   function automatic logic [2:0] last_data_idx(input len_e len);
      return (len == LEN_8) ? 3'd7 : 3'd6;
   endfunction

endpackage

// File: rtl/uart_tx_framer_parity.sv
// Combinational parity bit over the 7 or 8 data bits actually transmitted.
module uart_parity_gen
   import uart_tx_framer_pkg::*;
(
   input  logic [7:0] data_i,
   input  len_e       len_i,
   input  parity_e    ptype_i,
   output logic       parity_o,
   output logic       enable_o
);

   logic [7:0] masked;

   always_comb begin
      masked   = (len_i == LEN_8) ? data_i : {1'b0, data_i[6:0]};
      enable_o = parity_enabled(ptype_i);
      parity_o = ^masked;
      if (ptype_i == PAR_ODD) begin
         parity_o = ~parity_o;
      end
   end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 7/8 data bits LSB first, optional parity, 1/2 stop bits,
// each bit held for one BaudTick interval.
module uart_tx_framer
   import uart_tx_framer_pkg::*;
(
   input  logic       Clock,
   input  logic       ResetN,
   input  logic       BaudTick,
   input  logic       Send,
   input  logic [7:0] DataIn,
   input  logic       DataLength,
   input  logic [1:0] ParityType,
   input  logic       StopBits,
   output logic       TxOut,
   output logic       Busy,
   output logic       Done
);

   state_e     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] cnt_q, cnt_d;
   len_e       len_q, len_d;
   parity_e    ptype_q, ptype_d;
   logic       stop2_q, stop2_d;
   logic       tx_q, tx_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       par_bit, par_en;

   uart_parity_gen u_parity (
      .data_i   (data_q),
      .len_i    (len_q),
      .ptype_i  (ptype_q),
      .parity_o (par_bit),
      .enable_o (par_en)
   );

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         len_q   <= LEN_7;
         ptype_q <= PAR_NONE0;
         stop2_q <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ptype_q <= ptype_d;
         stop2_q <= stop2_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // TxOut is registered, so each transition loads the level of the bit being entered.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ptype_d = ptype_q;
      stop2_d = stop2_q;
      tx_d    = tx_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (Send && !done_q) begin
               data_d  = DataIn;
               shift_d = DataIn;
               len_d   = len_e'(DataLength);
               ptype_d = parity_e'(ParityType);
               stop2_d = StopBits;
               cnt_d   = '0;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (BaudTick) begin
               state_d = S_START;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (BaudTick) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
               cnt_d   = '0;
            end
         end
         S_DATA: begin
            if (BaudTick) begin
               if (cnt_q == last_data_idx(len_q)) begin
                  cnt_d = '0;
                  if (par_en) begin
                     state_d = S_PARITY;
                     tx_d    = par_bit;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  cnt_d   = cnt_q + 3'd1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         S_PARITY: begin
            if (BaudTick) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
               cnt_d   = '0;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (BaudTick) begin
               if (stop2_q && (cnt_q == 3'd0)) begin
                  cnt_d = 3'd1;
               end else begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      busy_d = (state_d != S_IDLE) || done_d;
   end

   assign TxOut = tx_q;
   assign Busy  = busy_q;
   assign Done  = done_q;

endmodule
